// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer feeding datamemory with word-aligned LW reads and lane-aligned stores.
// Define LSU_MISALIGN_EN to split misaligned accesses; without it a misaligned request returns resp_err.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  dm_memread,
    output logic                  dm_memwrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_funct3,
    input  logic [DATA_W-1:0]     dm_rd
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse and needs no acknowledge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
`ifdef LSU_MISALIGN_EN
        S_RD1  = 3'd2,
`endif
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                  state;
    logic [2:0]              f3_q;
    logic [1:0]              off_q;
    logic [DATA_W-1:0]       word0;
    logic [2*DATA_W-1:0]     dword;

`ifdef LSU_MISALIGN_EN
    logic [DATA_W-1:0]       word1;
    logic [DATA_W-1:0]       wdata_q;
    logic                    mis_q;
    logic [1:0]              cnt;
    logic [1:0]              cnt_next;
    logic [1:0]              last_idx;
`endif

    logic [2:0]              req_size;
    logic                    load_mis;
    logic                    store_mis;
    logic                    req_mis;
    logic                    req_illegal;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        load_mis  = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
        store_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_mis   = req_we ? store_mis : load_mis;
        if (req_we)
            req_illegal = (req_funct3 >= 3'b011);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    // Pick size bytes starting at byte off of the captured doubleword, then extend.
    function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] dw,
                                                  input logic [1:0]          off,
                                                  input logic [2:0]          f3);
        logic [DATA_W-1:0] s;
        s = DATA_W'(dw >> {off, 3'b000});
        case (f3[1:0])
            2'b00:   extract = f3[2] ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   extract = f3[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

`ifdef LSU_MISALIGN_EN
    assign dword    = {word1, word0};
    assign cnt_next = cnt + 2'd1;
    assign last_idx = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
`else
    assign dword    = {{DATA_W{1'b0}}, word0};
`endif

    // Captured words are cleared on accept, so stores and errors naturally yield zero.
    assign resp_rdata = (resp_valid && !resp_err) ? extract(dword, off_q, f3_q) : '0;
    assign req_ready  = (state == S_IDLE) && rst_n;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            f3_q        <= '0;
            off_q       <= '0;
            word0       <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            dm_memread  <= 1'b0;
            dm_memwrite <= 1'b0;
            dm_a        <= '0;
            dm_wd       <= '0;
            dm_funct3   <= '0;
`ifdef LSU_MISALIGN_EN
            word1       <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q  <= req_funct3;
                        off_q <= req_addr[1:0];
                        word0 <= '0;
`ifdef LSU_MISALIGN_EN
                        word1   <= '0;
                        wdata_q <= req_wdata;
                        mis_q   <= req_mis;
                        cnt     <= '0;
                        if (req_illegal) begin
`else
                        if (req_illegal || req_mis) begin
`endif
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state      <= S_RD0;
                            dm_memread <= 1'b1;
                            dm_a       <= {req_addr[DM_ADDRESS-1:2], 2'b00};
                            dm_funct3  <= 3'b010;
                        end else begin
                            state       <= S_WR;
                            dm_memwrite <= 1'b1;
                            dm_a        <= req_addr;
`ifdef LSU_MISALIGN_EN
                            if (req_mis) begin
                                dm_funct3 <= 3'b000;
                                dm_wd     <= {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                            end else
`endif
                            begin
                                dm_funct3 <= req_funct3;
                                dm_wd     <= req_wdata;
                            end
                        end
                    end
                end

                S_RD0: begin
                    word0 <= dm_rd;
`ifdef LSU_MISALIGN_EN
                    if (mis_q) begin
                        state <= S_RD1;
                        dm_a  <= dm_a + DM_ADDRESS'(4);
                    end else
`endif
                    begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        dm_memread <= 1'b0;
                        dm_a       <= '0;
                        dm_funct3  <= '0;
                    end
                end

`ifdef LSU_MISALIGN_EN
                S_RD1: begin
                    word1      <= dm_rd;
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    dm_memread <= 1'b0;
                    dm_a       <= '0;
                    dm_funct3  <= '0;
                end
`endif

                S_WR: begin
`ifdef LSU_MISALIGN_EN
                    // Misaligned stores walk one byte per cycle; address wraps with dm_a width.
                    if (mis_q && (cnt != last_idx)) begin
                        cnt   <= cnt_next;
                        dm_a  <= dm_a + DM_ADDRESS'(1);
                        dm_wd <= {{(DATA_W-8){1'b0}}, wdata_q[{cnt_next, 3'b000} +: 8]};
                    end else
`endif
                    begin
`ifdef LSU_MISALIGN_EN
                        cnt <= '0;
`endif
                        state       <= S_RESP;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b0;
                        dm_memwrite <= 1'b0;
                        dm_a        <= '0;
                        dm_wd       <= '0;
                        dm_funct3   <= '0;
                    end
                end

                S_RESP: begin
                    state    <= S_IDLE;
                    resp_err <= 1'b0;
                end

                default: begin
                    state       <= S_IDLE;
                    resp_err    <= 1'b0;
                    dm_memread  <= 1'b0;
                    dm_memwrite <= 1'b0;
                    dm_a        <= '0;
                    dm_wd       <= '0;
                    dm_funct3   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array datamemory model; expectations are hand-computed.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int AW = 9;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          busy;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          dm_memread;
    logic          dm_memwrite;
    logic [AW-1:0] dm_a;
    logic [31:0]   dm_wd;
    logic [2:0]    dm_funct3;
    logic [31:0]   dm_rd;

    load_store_unit #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_memread(dm_memread), .dm_memwrite(dm_memwrite), .dm_a(dm_a),
        .dm_wd(dm_wd), .dm_funct3(dm_funct3), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // datamemory model: byte array, combinational word read, lane write on posedge
    logic [7:0]    mem [0:511];
    logic [AW-1:0] ma1, ma2, ma3;
    always_comb begin
        ma1 = dm_a + 9'd1;
        ma2 = dm_a + 9'd2;
        ma3 = dm_a + 9'd3;
        dm_rd = dm_memread ? {mem[ma3], mem[ma2], mem[ma1], mem[dm_a]} : 32'h0;
    end
    always @(posedge clk) begin
        if (dm_memwrite) begin
            mem[dm_a] <= dm_wd[7:0];
            if (dm_funct3[1:0] != 2'b00) mem[ma1] <= dm_wd[15:8];
            if (dm_funct3[1:0] == 2'b10) begin
                mem[ma2] <= dm_wd[23:16];
                mem[ma3] <= dm_wd[31:24];
            end
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat;
    int          n_rd;
    int          n_wr;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        busy_c1;
    logic [8:0]  rd_a [8];
    logic [8:0]  wr_a [8];
    logic [31:0] wr_wd [8];
    logic [2:0]  wr_f3 [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wd);
        int   guard;
        logic seen;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_rd = 0; n_wr = 0; lat = 0; got_rdata = '0; got_err = 1'b0; seen = 1'b0; busy_c1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) busy_c1 = busy;
            if (dm_memread) begin
                if (n_rd < 8) rd_a[n_rd] = dm_a;
                n_rd++;
            end
            if (dm_memwrite) begin
                if (n_wr < 8) begin
                    wr_a[n_wr] = dm_a; wr_wd[n_wr] = dm_wd; wr_f3[n_wr] = dm_funct3;
                end
                n_wr++;
            end
            if (resp_valid) begin
                lat = c; got_rdata = resp_rdata; got_err = resp_err; seen = 1'b1;
                break;
            end
        end
        check("resp_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic expect_resp(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                               input logic exp_err);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_err"}, {31'b0, got_err}, {31'b0, exp_err});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {26'b0, req_ready, busy, resp_valid, resp_err, dm_memread, dm_memwrite}, 32'h0);
        check({tag, "_a_f3"}, {20'b0, dm_funct3, dm_a}, 32'h0);
        check({tag, "_wd"}, dm_wd, 32'h0);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic seen_resp;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Aligned SW then LW
        do_req(1'b1, F_W, 9'h010, 32'hDEADBEEF);
        expect_resp("sw_al", 2, 32'h0, 1'b0);
        check("sw_al_nwr", n_wr, 1);
        check("sw_al_f3", {29'b0, wr_f3[0]}, 32'h2);
        check("sw_al_a", {23'b0, wr_a[0]}, 32'h010);
        check("sw_al_wd", wr_wd[0], 32'hDEADBEEF);
        check("sw_al_busy", {31'b0, busy_c1}, 32'd1);
        do_req(1'b0, F_W, 9'h010, 32'h0);
        expect_resp("lw_al", 2, 32'hDEADBEEF, 1'b0);
        check("lw_al_nrd", n_rd, 1);

        // Preload two words
        do_req(1'b1, F_W, 9'h010, 32'h44332211);
        do_req(1'b1, F_W, 9'h014, 32'h88776655);

`ifdef LSU_MISALIGN_EN
        do_req(1'b0, F_W, 9'h012, 32'h0);
        expect_resp("lw_mis12", 3, 32'h66554433, 1'b0);
        check("lw_mis12_nrd", n_rd, 2);
        check("lw_mis12_a0", {23'b0, rd_a[0]}, 32'h010);
        check("lw_mis12_a1", {23'b0, rd_a[1]}, 32'h014);
        do_req(1'b0, F_W, 9'h011, 32'h0);
        expect_resp("lw_mis11", 3, 32'h55443322, 1'b0);
        do_req(1'b0, F_H, 9'h013, 32'h0);
        expect_resp("lh_mis13", 3, 32'h00005544, 1'b0);
`else
        do_req(1'b0, F_W, 9'h012, 32'h0);
        expect_resp("lw_mis12", 1, 32'h0, 1'b1);
        check("lw_mis12_nrd", n_rd, 0);
        do_req(1'b0, F_W, 9'h011, 32'h0);
        expect_resp("lw_mis11", 1, 32'h0, 1'b1);
        check("lw_mis11_nacc", n_rd + n_wr, 0);
        do_req(1'b0, F_H, 9'h013, 32'h0);
        expect_resp("lh_mis13", 1, 32'h0, 1'b1);
`endif

        // Aligned sub-word loads with sign and zero extension
        do_req(1'b0, F_B, 9'h017, 32'h0);
        expect_resp("lb_17", 2, 32'hFFFFFF88, 1'b0);
        do_req(1'b0, F_BU, 9'h017, 32'h0);
        expect_resp("lbu_17", 2, 32'h00000088, 1'b0);
        do_req(1'b0, F_H, 9'h016, 32'h0);
        expect_resp("lh_16", 2, 32'hFFFF8877, 1'b0);
        do_req(1'b0, F_HU, 9'h016, 32'h0);
        expect_resp("lhu_16", 2, 32'h00008877, 1'b0);
        do_req(1'b0, F_H, 9'h012, 32'h0);
        expect_resp("lh_12", 2, 32'h00004433, 1'b0);
        check("lh_12_a", {23'b0, rd_a[0]}, 32'h010);

        // Lane stores
        do_req(1'b1, F_W, 9'h020, 32'h0);
        do_req(1'b1, F_B, 9'h021, 32'hFFFFFF5A);
        check("sb_f3", {29'b0, wr_f3[0]}, 32'h0);
        check("sb_wd", wr_wd[0], 32'hFFFFFF5A);
        do_req(1'b1, F_H, 9'h022, 32'h1234BEEF);
        check("sh_f3", {29'b0, wr_f3[0]}, 32'h1);
        do_req(1'b0, F_W, 9'h020, 32'h0);
        expect_resp("lw_20", 2, 32'hBEEF5A00, 1'b0);

        // Misaligned stores, including address wrap
        do_req(1'b1, F_W, 9'h040, 32'h0);
`ifdef LSU_MISALIGN_EN
        do_req(1'b1, F_W, 9'h1FE, 32'hA1B2C3D4);
        expect_resp("sw_wrap", 5, 32'h0, 1'b0);
        check("sw_wrap_nwr", n_wr, 4);
        check("sw_wrap_a0", {23'b0, wr_a[0]}, 32'h1FE);
        check("sw_wrap_a1", {23'b0, wr_a[1]}, 32'h1FF);
        check("sw_wrap_a2", {23'b0, wr_a[2]}, 32'h000);
        check("sw_wrap_a3", {23'b0, wr_a[3]}, 32'h001);
        check("sw_wrap_wd0", wr_wd[0], 32'h000000D4);
        check("sw_wrap_wd1", wr_wd[1], 32'h000000C3);
        check("sw_wrap_wd2", wr_wd[2], 32'h000000B2);
        check("sw_wrap_wd3", wr_wd[3], 32'h000000A1);
        check("sw_wrap_f3", {29'b0, wr_f3[3]}, 32'h0);
        do_req(1'b0, F_HU, 9'h1FE, 32'h0);
        expect_resp("lhu_1fe", 2, 32'h0000C3D4, 1'b0);
        do_req(1'b0, F_HU, 9'h000, 32'h0);
        expect_resp("lhu_000", 2, 32'h0000A1B2, 1'b0);
        do_req(1'b1, F_H, 9'h041, 32'h0000CAFE);
        expect_resp("sh_mis", 3, 32'h0, 1'b0);
        check("sh_mis_nwr", n_wr, 2);
        do_req(1'b0, F_W, 9'h040, 32'h0);
        expect_resp("lw_40", 2, 32'h00CAFE00, 1'b0);
`else
        do_req(1'b1, F_W, 9'h1FE, 32'hA1B2C3D4);
        expect_resp("sw_wrap", 1, 32'h0, 1'b1);
        check("sw_wrap_nwr", n_wr, 0);
        do_req(1'b1, F_H, 9'h041, 32'h0000CAFE);
        expect_resp("sh_mis", 1, 32'h0, 1'b1);
        do_req(1'b0, F_W, 9'h040, 32'h0);
        expect_resp("lw_40", 2, 32'h00000000, 1'b0);
`endif

        // Illegal encodings
        do_req(1'b0, 3'b011, 9'h010, 32'h0);
        expect_resp("ill_ld011", 1, 32'h0, 1'b1);
        check("ill_ld011_nrd", n_rd, 0);
        do_req(1'b0, 3'b111, 9'h010, 32'h0);
        expect_resp("ill_ld111", 1, 32'h0, 1'b1);
        do_req(1'b1, 3'b011, 9'h010, 32'h0);
        expect_resp("ill_st011", 1, 32'h0, 1'b1);
        check("ill_st011_nwr", n_wr, 0);
        do_req(1'b1, 3'b100, 9'h010, 32'h0);
        expect_resp("ill_st100", 1, 32'h0, 1'b1);

        // Reset in the middle of a transaction
        do_req(1'b1, F_W, 9'h030, 32'h0);
        do_req(1'b1, F_W, 9'h034, 32'h0);
        @(negedge clk);
`ifdef LSU_MISALIGN_EN
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 9'h031; req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_b0_a", {23'b0, dm_a}, 32'h031);
        check("rst_b0_wd", dm_wd, 32'h00000044);
        @(negedge clk);
        check("rst_b1_a", {23'b0, dm_a}, 32'h032);
`else
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 9'h010; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_rd0", {22'b0, dm_memread, dm_a}, 32'h210);
`endif
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        seen_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        check("midrst_no_resp", {31'b0, seen_resp}, 32'h0);
        rst_n = 1'b1;
`ifdef LSU_MISALIGN_EN
        do_req(1'b0, F_W, 9'h030, 32'h0);
        expect_resp("after_rst_30", 2, 32'h00004400, 1'b0);
        do_req(1'b0, F_W, 9'h034, 32'h0);
        expect_resp("after_rst_34", 2, 32'h00000000, 1'b0);
`else
        do_req(1'b0, F_W, 9'h010, 32'h0);
        expect_resp("after_rst_10", 2, 32'h44332211, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store sequencer between the EX/MEM pipeline register and `datamemory`. Accepts one load or store request at a time and issues only accesses `datamemory` handles correctly: word-aligned LW reads, plus SB/SH/SW writes on naturally aligned lanes. Misaligned loads become two word reads with byte assembly and sign/zero extension. Misaligned stores become a sequence of byte stores. `busy` stalls the pipeline until the response is delivered.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width, matches `datamemory`
- DATA_W, 32, data width; fixed at 32

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW)
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- busy  out  1  high in any state except IDLE
- resp_valid  out  1  one-cycle pulse, result ready
- resp_rdata  out  DATA_W  load result, extended; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; request was not executed
- dm_memread  out  1  to `datamemory` MemRead
- dm_memwrite  out  1  to `datamemory` MemWrite
- dm_a  out  DM_ADDRESS  to `datamemory` a
- dm_wd  out  DATA_W  to `datamemory` wd
- dm_funct3  out  3  to `datamemory` Funct3
- dm_rd  in  DATA_W  from `datamemory` rd; sampled at the rising edge that ends the read cycle

## Operation
- Size: funct3[1:0] gives 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes. funct3[2] = 1 means unsigned (loads only).
- Illegal funct3: loads 011/110/111; stores with funct3 ≥ 011.
- off = addr[1:0]. An access is misaligned when off + size > 4 for loads, and when off is not a multiple of size for stores.
- States and transitions:
  - IDLE -> RD0 on an accepted load.
  - IDLE -> WR on an accepted store.
  - IDLE -> RESP on an illegal request, and on a misaligned request when LSU_MISALIGN_EN is undefined. These set resp_err = 1.
  - RD0: dm_memread = 1, dm_a = {addr[DM_ADDRESS-1:2], 2'b00}, dm_funct3 = 010. Captures word0. Goes to RD1 if misaligned, otherwise RESP.
  - RD1: same as RD0 with dm_a = word address + 4, wrapping modulo 2^DM_ADDRESS. Captures word1, then goes to RESP.
  - WR, aligned store: one cycle. dm_memwrite = 1, dm_a = addr, dm_wd = req_wdata, dm_funct3 = req_funct3. Then RESP.
  - WR, misaligned store: runs a 2-bit byte counter i from 0 to size−1. Each cycle: dm_memwrite = 1, dm_funct3 = 000, dm_a = addr + i (wraps), dm_wd = {24'b0, wdata byte i}. Goes to RESP after the byte with i = size−1.
  - RESP: resp_valid = 1 for one cycle, then IDLE.
- Load assembly: form a 64-bit value {word1, word0}, take size bytes starting at byte off, then sign- or zero-extend to 32 bits.
- Outputs to `datamemory` are held at 0 in IDLE and RESP.
- The request is latched on acceptance. Request inputs are ignored outside IDLE.
- req_ready = 1 only in IDLE with rst_n high.

## Timing
- Reset (asynchronous): state = IDLE, counter = 0, all outputs 0 including req_ready, captured words = 0.
- Latency from the accept edge to resp_valid high:
  - aligned load or aligned store: 2 cycles
  - misaligned load: 3 cycles
  - misaligned store: size + 1 cycles
  - error: 1 cycle
- Back-to-back requests: the next request can be accepted in the cycle after RESP.
- Reset during a misaligned store: bytes already written stay in memory (no rollback), no response is produced, and the unit restarts in IDLE.
- Address wrap-around: an access at addr = 0x1FE of size 4 touches 0x1FE, 0x1FF, 0x000, 0x001.

## Configuration
- LSU_MISALIGN_EN defined: misaligned loads and stores are split as described above.
- LSU_MISALIGN_EN undefined: a misaligned request goes directly to RESP with resp_err = 1 and resp_rdata = 0, and makes no memory access. The RD1 state and the byte counter are not built.

## Test plan
- Aligned SW addr 0x010, data 0xDEADBEEF, then LW addr 0x010 -> one write cycle with dm_funct3 = 010; load resp_rdata = 0xDEADBEEF, 2 cycles after accept.
- Memory words 0x013..0x010 = 0x44332211 and 0x017..0x014 = 0x88776655; LW addr 0x012 -> two read cycles (dm_a = 0x010, then 0x014); resp_rdata = 0x66554433 at 3 cycles.
- Same memory; LH addr 0x013 -> resp_rdata = 0x00005544. LB addr 0x017 -> 0xFFFFFF88. LBU addr 0x017 -> 0x00000088.
- SW addr 0x1FE, data 0xA1B2C3D4 -> four SB cycles at dm_a = 0x1FE, 0x1FF, 0x000, 0x001 with dm_wd low byte = D4, C3, B2, A1; resp at 5 cycles.
- req_funct3 = 011 (load) -> resp_err = 1 one cycle after accept, no dm_memread. With LSU_MISALIGN_EN undefined, LW addr 0x011 -> resp_err = 1 and no memory access.
- Assert rst_n low during the 2nd byte of a misaligned SW -> all outputs go to 0 immediately; the 1st byte stays written; no resp_valid; after release the next request is accepted normally.
